// File: rtl/port_bus_master.sv
// port_bus_master: queued initiator that replays read/write commands as PacoBlaze3-timed port bus cycles.
//
// Parameters
//   ADDR_W      port_id width
//   DATA_W      data width
//   FIFO_DEPTH  command queue entries (power of two, >= 2)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-low reset
//   cmd_valid     command offered
//   cmd_ready     queue can accept a command (!full)
//   cmd_write     1 = OUTPUT (write), 0 = INPUT (read)
//   cmd_addr      target port id
//   cmd_data      write data, ignored for reads
//   rsp_valid     read data available, held until rsp_ready
//   rsp_ready     consumer accepts read data
//   rsp_data      read result
//   port_id       bus port address, holds between cycles
//   out_port      bus write data, holds between cycles and across reads
//   write_strobe  one-cycle write qualifier
//   read_strobe   one-cycle read qualifier
//   in_port       bus read data, sampled at the end of the strobe cycle
//   busy          queue non-empty or a bus cycle / response pending
module port_bus_master #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] port_id,
   output logic [DATA_W-1:0] out_port,
   output logic              write_strobe,
   output logic              read_strobe,
   input  logic [DATA_W-1:0] in_port,
   output logic              busy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, RESP} state_t;
   state_t state_q, state_d;
   logic              wr_mem   [FIFO_DEPTH];
   logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              full, empty, push, pop;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] port_id_q, port_id_d;
   logic [DATA_W-1:0] out_port_q, out_port_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_valid_q, rsp_valid_d;
   assign full  = cnt_q == CW'(FIFO_DEPTH);
   assign empty = cnt_q == '0;
   // a full queue refuses a push even when a pop frees a slot at the same edge
   assign push  = cmd_valid & ~full;
   always_ff @(posedge clk)
      if (push) begin
         wr_mem[wr_ptr_q]   <= cmd_write;
         addr_mem[wr_ptr_q] <= cmd_addr;
         data_mem[wr_ptr_q] <= cmd_data;
      end
   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         IDLE: begin
            pop     = ~empty;
            state_d = empty ? IDLE : SETUP;
         end
         SETUP:  state_d = STROBE;
         STROBE:
            if (wr_q) begin
               pop     = ~empty;
               state_d = empty ? IDLE : SETUP;
            end else begin
               rsp_data_d  = in_port;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         RESP:
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               pop         = ~empty;
               state_d     = empty ? IDLE : SETUP;
            end
         default: state_d = IDLE;
      endcase
   end
   // the head is consumed at the edge entering SETUP, so the bus fields load there
   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d      = cnt_q + CW'(push) - CW'(pop);
      wr_d       = pop ? wr_mem[rd_ptr_q] : wr_q;
      port_id_d  = pop ? addr_mem[rd_ptr_q] : port_id_q;
      out_port_d = (pop & wr_mem[rd_ptr_q]) ? data_mem[rd_ptr_q] : out_port_q;
   end
   always_ff @(posedge clk)
      if (!rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         port_id_q   <= '0;
         out_port_q  <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         port_id_q   <= port_id_d;
         out_port_q  <= out_port_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
      end
   // strobes decode from registered state, so a reset edge mid-STROBE drops them at once
   assign write_strobe = (state_q == STROBE) & wr_q;
   assign read_strobe  = (state_q == STROBE) & ~wr_q;
   assign cmd_ready    = ~full;
   assign busy         = (state_q != IDLE) | ~empty;
   assign port_id      = port_id_q;
   assign out_port     = out_port_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_valid    = rsp_valid_q;
endmodule

// File: tb/tb_port_bus_master.sv
// tb_port_bus_master: directed self-checking bench for port_bus_master.
module tb_port_bus_master;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
   logic [7:0] cmd_addr = '0, cmd_data = '0, in_port = '0;
   logic       cmd_ready, rsp_valid, write_strobe, read_strobe, busy;
   logic [7:0] rsp_data, port_id, out_port;
   int n_chk = 0, n_fail = 0;
   int ws_cnt = 0, rs_cnt = 0, rsp_cnt = 0, overlap = 0;
   logic [7:0] last_rsp = '0, out_at_read = '0;
   port_bus_master dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .port_id(port_id), .out_port(out_port), .write_strobe(write_strobe),
      .read_strobe(read_strobe), .in_port(in_port), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (write_strobe) ws_cnt++;
      if (read_strobe) begin
         rs_cnt++;
         out_at_read = out_port;
      end
      if (write_strobe && read_strobe) overlap++;
      if (rsp_valid && rsp_ready) begin
         rsp_cnt++;
         last_rsp = rsp_data;
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_data  = d;
      tick();
      cmd_valid = 1'b0;
   endtask
   task automatic idle_outs(input string tag);
      chk({tag, "_ws"}, 32'(write_strobe), 0);
      chk({tag, "_rs"}, 32'(read_strobe), 0);
   endtask
   int ws0, rs0, rsp0;
   initial begin
      tick();
      tick();
      rst = 1'b1;
      chk("rst_port_id", 32'(port_id), 0);
      chk("rst_out_port", 32'(out_port), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      idle_outs("rst");
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      // single write 0x5A -> 0x03
      push(1'b1, 8'h03, 8'h5A);
      chk("w1_busy_queued", 32'(busy), 1);
      idle_outs("w1_idle");
      tick();
      chk("w1_setup_port", 32'(port_id), 32'h03);
      chk("w1_setup_data", 32'(out_port), 32'h5A);
      idle_outs("w1_setup");
      tick();
      chk("w1_strobe_ws", 32'(write_strobe), 1);
      chk("w1_strobe_rs", 32'(read_strobe), 0);
      tick();
      idle_outs("w1_after");
      chk("w1_busy_after", 32'(busy), 0);
      chk("w1_rsp_valid", 32'(rsp_valid), 0);
      chk("w1_ws_count", 32'(ws_cnt), 1);
      // single read 0x01 -> 0xC3
      in_port   = 8'hC3;
      rsp_ready = 1'b1;
      push(1'b0, 8'h01, 8'h00);
      tick();
      chk("r1_setup_port", 32'(port_id), 32'h01);
      chk("r1_out_held", 32'(out_port), 32'h5A);
      idle_outs("r1_setup");
      tick();
      chk("r1_strobe_rs", 32'(read_strobe), 1);
      chk("r1_strobe_ws", 32'(write_strobe), 0);
      tick();
      chk("r1_rsp_valid", 32'(rsp_valid), 1);
      chk("r1_rsp_data", 32'(rsp_data), 32'hC3);
      idle_outs("r1_resp");
      tick();
      chk("r1_rsp_cleared", 32'(rsp_valid), 0);
      chk("r1_busy_after", 32'(busy), 0);
      // read 0x07 stalled 10 cycles with a queued write 0x88 -> 0x08
      rsp_ready = 1'b0;
      in_port   = 8'h77;
      push(1'b0, 8'h07, 8'h00);
      push(1'b1, 8'h08, 8'h88);
      tick();
      chk("st_strobe_rs", 32'(read_strobe), 1);
      tick();
      in_port = 8'h00;
      for (int i = 0; i < 10; i++) begin
         chk("st_rsp_valid", 32'(rsp_valid), 1);
         chk("st_rsp_data", 32'(rsp_data), 32'h77);
         chk("st_port_id", 32'(port_id), 32'h07);
         idle_outs("st_hold");
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      chk("st_rsp_done", 32'(rsp_valid), 0);
      chk("st_wsetup_port", 32'(port_id), 32'h08);
      chk("st_wsetup_data", 32'(out_port), 32'h88);
      idle_outs("st_wsetup");
      tick();
      chk("st_w_strobe", 32'(write_strobe), 1);
      tick();
      chk("st_busy_after", 32'(busy), 0);
      // fill the queue behind a stalled read, then drain back-to-back writes
      rsp_ready = 1'b0;
      in_port   = 8'h3C;
      push(1'b0, 8'h30, 8'h00);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 8'h20;
      for (int k = 0; k < 4; k++) begin
         chk("ff_ready_before_push", 32'(cmd_ready), 1);
         cmd_data = 8'h10 + 8'(k);
         tick();
      end
      chk("ff_full_ready", 32'(cmd_ready), 0);
      chk("ff_rsp_data", 32'(rsp_data), 32'h3C);
      cmd_data = 8'h14;
      tick();
      chk("ff_still_full", 32'(cmd_ready), 0);
      rsp_ready = 1'b1;
      tick();
      chk("ff_ready_after_pop", 32'(cmd_ready), 1);
      chk("ff_setup0_data", 32'(out_port), 32'h10);
      chk("ff_setup0_port", 32'(port_id), 32'h20);
      tick();
      cmd_valid = 1'b0;
      chk("ff_strobe0", 32'(write_strobe), 1);
      chk("ff_5th_accepted", 32'(cmd_ready), 0);
      for (int k = 1; k < 5; k++) begin
         tick();
         chk("ff_setup_ws", 32'(write_strobe), 0);
         chk("ff_setup_data", 32'(out_port), 32'h10 + k);
         tick();
         chk("ff_strobe_ws", 32'(write_strobe), 1);
         chk("ff_strobe_data", 32'(out_port), 32'h10 + k);
      end
      tick();
      chk("ff_busy_after", 32'(busy), 0);
      // reset during the strobe of the first of three queued writes
      push(1'b1, 8'h40, 8'hA1);
      push(1'b1, 8'h41, 8'hA2);
      push(1'b1, 8'h42, 8'hA3);
      chk("rs_in_strobe", 32'(write_strobe), 1);
      rst = 1'b0;
      tick();
      chk("rs_ws", 32'(write_strobe), 0);
      chk("rs_port_id", 32'(port_id), 0);
      chk("rs_out_port", 32'(out_port), 0);
      chk("rs_rsp_data", 32'(rsp_data), 0);
      chk("rs_rsp_valid", 32'(rsp_valid), 0);
      chk("rs_cmd_ready", 32'(cmd_ready), 1);
      chk("rs_busy", 32'(busy), 0);
      rst = 1'b1;
      ws0 = ws_cnt;
      repeat (8) tick();
      chk("rs_no_strobes", 32'(ws_cnt), 32'(ws0));
      chk("rs_busy_later", 32'(busy), 0);
      // write / read / write with in_port 0x99
      in_port = 8'h99;
      ws0  = ws_cnt;
      rs0  = rs_cnt;
      rsp0 = rsp_cnt;
      push(1'b1, 8'h01, 8'hE1);
      push(1'b0, 8'h02, 8'h00);
      push(1'b1, 8'h03, 8'hE3);
      repeat (12) tick();
      chk("wrw_busy", 32'(busy), 0);
      chk("wrw_ws", 32'(ws_cnt - ws0), 2);
      chk("wrw_rs", 32'(rs_cnt - rs0), 1);
      chk("wrw_rsp_count", 32'(rsp_cnt - rsp0), 1);
      chk("wrw_rsp_data", 32'(last_rsp), 32'h99);
      chk("wrw_out_in_read", 32'(out_at_read), 32'hE1);
      chk("wrw_out_final", 32'(out_port), 32'hE3);
      chk("no_overlap", 32'(overlap), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/port_bus_master.md
# port_bus_master

Initiator for the PacoBlaze 8-bit port bus. Accepts queued read and write commands over a valid/ready interface. Replays each command as a PacoBlaze3-timed INPUT or OUTPUT cycle on port_id/out_port/write_strobe/read_strobe/in_port, and returns read data over a second valid/ready interface. It lets a non-CPU agent (host bridge, bench, DMA helper) drive io_bamse-style peripherals exactly as the processor does.

## Interface
- ADDR_W, 8, port_id width.
- DATA_W, 8, data width.
- FIFO_DEPTH, 4, command queue entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue can accept a command.
- cmd_write  in  1  1 = OUTPUT (write), 0 = INPUT (read).
- cmd_addr  in  ADDR_W  target port id.
- cmd_data  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts read data.
- rsp_data  out  DATA_W  read result.
- port_id  out  ADDR_W  bus port address.
- out_port  out  DATA_W  bus write data.
- write_strobe  out  1  one-cycle write qualifier.
- read_strobe  out  1  one-cycle read qualifier.
- in_port  in  DATA_W  bus read data from the responder.
- busy  out  1  queue non-empty or a bus cycle or response is pending.

## Operation
- Command FIFO, FIFO_DEPTH entries of {write, addr, data}:
  - Push on cmd_valid & cmd_ready.
  - cmd_ready = !full. A push is refused while full even if a pop happens in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- FSM states: IDLE, SETUP, STROBE, RESP.
- IDLE -> SETUP when the FIFO is non-empty. The head is popped on entry to SETUP, and port_id/out_port load from the head at that edge.
  - out_port loads only for writes; it holds its previous value on reads.
- SETUP -> STROBE unconditionally. write_strobe or read_strobe is high for the whole STROBE cycle only.
- STROBE, write: go to SETUP if the FIFO is non-empty, else IDLE.
- STROBE, read: rsp_data <= in_port at the edge ending STROBE, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid and rsp_data are held stable until rsp_ready.
  - On handshake: rsp_valid <= 0, then go to SETUP if the FIFO is non-empty, else IDLE.
  - No bus cycle starts while in RESP; responses stay strictly in command order.
- port_id and out_port hold their last values between cycles, as the processor does. Strobes are never high in IDLE, SETUP or RESP.
- Never assert both strobes in the same cycle.
- busy = (state != IDLE) | !empty.
- Reset (rst low at a clock edge):
  - state IDLE; FIFO flushed (pointers and count 0).
  - port_id, out_port and rsp_data = 0.
  - write_strobe, read_strobe and rsp_valid = 0.
  - cmd_ready = 1 and busy = 0 from the first cycle after reset.
  - Reset mid-STROBE drops the strobe at that edge; the partial cycle is not retried.

## Timing
- Bus cycle is 2 clocks (SETUP + STROBE), matching PacoBlaze3 INPUT/OUTPUT.
  - port_id/out_port are valid in both cycles; the strobe is in the second.
  - in_port is sampled at the end of the second cycle.
- Command pushed into an empty idle queue at edge N: SETUP in cycle N+1, strobe in cycle N+2.
- Back-to-back writes: one strobe every 2 cycles with no idle gap.
- Read: rsp_valid rises the cycle after read_strobe. With rsp_ready tied high, the next bus cycle's SETUP is the cycle after rsp_valid, so reads take 3 cycles each.
- The responder must present in_port combinationally from port_id during STROBE.

## Test plan
- Write 0x5A to 0x03 from reset: SETUP cycle port_id=0x03, out_port=0x5A, strobes low. Next cycle write_strobe=1 for exactly one cycle. rsp_valid never asserts; busy returns low after.
- Read 0x01 with in_port=0xC3: read_strobe one cycle. Next cycle rsp_valid=1 with rsp_data=0xC3. Handshake with rsp_ready=1 clears rsp_valid.
- Push 5 writes (0x10..0x14 to port 0x20) back-to-back with cmd_valid held high:
  - Pushes 1–4 accepted; cmd_ready low on the cycle after the 4th push (FIFO full), 5th push not yet accepted.
  - cmd_ready rises the cycle after the 1st pop; 5th accepted then.
  - write_strobe pulses every 2 cycles with out_port 0x10..0x14 in order.
- Read of port 0x07, then a queued write to 0x08, with rsp_ready held low 10 cycles:
  - rsp_valid and rsp_data stay stable; no strobe and port_id stays 0x07 throughout.
  - Write SETUP occurs the cycle after the rsp handshake.
- Assert rst low during the STROBE of the first of 3 queued writes:
  - Next cycle all outputs are 0, cmd_ready=1, busy=0.
  - No further strobes occur for the discarded commands.
- Alternate write/read/write to ports 0x01/0x02/0x03 with in_port=0x99:
  - Strobes never overlap; exactly one response (0x99).
  - out_port stays 0x??-of-first-write during the read cycle.
